// File: rtl/kf76489_bus_writer_if.sv
// Host request handshake plus KF76489 write bus, bundled for the bus writer.
// The slave side belongs to the writer; the master side is the host/chip environment.
interface kf76489_bus_writer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_channel;
    logic       req_attn;
    logic [9:0] req_data;
    logic       CE_N;
    logic       WE_N;
    logic [7:0] D_OUT;
    logic       READY;
    logic       done;
    logic       timeout_err;

    modport slave (
        input  req_valid, req_channel, req_attn, req_data, READY,
        output req_ready, CE_N, WE_N, D_OUT, done, timeout_err
    );

    modport master (
        output req_valid, req_channel, req_attn, req_data, READY,
        input  req_ready, CE_N, WE_N, D_OUT, done, timeout_err
    );
endinterface

// File: rtl/kf76489_bus_writer.sv
// Converts host register-write requests into one or two KF76489 bus bytes,
// each framed by setup, READY-terminated strobe (with timeout) and gap phases.
module kf76489_bus_writer #(
    parameter int SETUP_CYCLES = 1,
    parameter int MIN_STROBE   = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    kf76489_bus_writer_if.slave     bus
);
    localparam int CW = $clog2(TIMEOUT + MIN_STROBE + SETUP_CYCLES + GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    dout_q, dout_d;
    logic [7:0]    byte2_q, byte2_d;
    logic          pend_q, pend_d;
    logic          tmo_q, tmo_d;
    logic          ce_n_q, ce_n_d;

    logic [2:0]    addr;
    logic [7:0]    first_byte;
    logic [7:0]    second_byte;
    logic          is_noise_ctl;
    logic          accept;
    logic          strobe_ok;
    logic          strobe_tmo;
    logic          gap_last;

    // Byte formatting: the chip numbers bits MSB-first, so fields are bit-reversed.
    always_comb begin
        addr         = {bus.req_channel, bus.req_attn};
        is_noise_ctl = (bus.req_channel == 2'd3) && !bus.req_attn;
        first_byte   = {bus.req_data[0], bus.req_data[1], bus.req_data[2], bus.req_data[3],
                        addr[0], addr[1], addr[2], 1'b1};
        if (is_noise_ctl)
            first_byte[7:4] = {bus.req_data[1], bus.req_data[0], bus.req_data[2], 1'b0};
        second_byte  = {bus.req_data[4], bus.req_data[5], bus.req_data[6],
                        bus.req_data[7], bus.req_data[8], bus.req_data[9], 2'b00};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dout_q  <= 8'hFF;
            byte2_q <= 8'h00;
            pend_q  <= 1'b0;
            tmo_q   <= 1'b0;
            ce_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            byte2_q <= byte2_d;
            pend_q  <= pend_d;
            tmo_q   <= tmo_d;
            ce_n_q  <= ce_n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        dout_d     = dout_q;
        byte2_d    = byte2_q;
        pend_d     = pend_q;
        tmo_d      = tmo_q;
        accept     = bus.req_valid && (state_q == IDLE);
        // READY is only honoured once the minimum strobe width has elapsed.
        strobe_ok  = (cnt_q >= CW'(MIN_STROBE - 1)) && bus.READY;
        strobe_tmo = (cnt_q == CW'(TIMEOUT - 1)) && !strobe_ok;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = SETUP;
                    dout_d  = first_byte;
                    byte2_d = second_byte;
                    pend_d  = !bus.req_attn && (bus.req_channel != 2'd3);
                    tmo_d   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    state_d = STROBE;
                    cnt_d   = '0;
                end
            end
            STROBE: begin
                if (strobe_ok) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (strobe_tmo) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (pend_q) begin
                        state_d = SETUP;
                        dout_d  = byte2_q;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobe lines are a flop of the next state, so they never glitch.
        ce_n_d = (state_d != STROBE);
    end

    always_comb begin
        gap_last        = (state_q == GAP) && (cnt_q == CW'(GAP_CYCLES - 1));
        bus.req_ready   = (state_q == IDLE) && !reset;
        bus.done        = gap_last && !pend_q && !reset;
        bus.timeout_err = gap_last && !pend_q && tmo_q && !reset;
        bus.CE_N        = ce_n_q;
        bus.WE_N        = ce_n_q;
        bus.D_OUT       = dout_q;
    end
endmodule

// File: tb/tb_kf76489_bus_writer.sv
// Directed bench for kf76489_bus_writer: byte table plus handshake/reset sequences.
module tb_kf76489_bus_writer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    kf76489_bus_writer_if bus();

    kf76489_bus_writer #(
        .SETUP_CYCLES(1), .MIN_STROBE(4), .GAP_CYCLES(2), .TIMEOUT(255)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0] ch;
        logic       attn;
        logic [9:0] data;
        int         dly;   // strobe cycles READY stays low
        int         nb;
        logic [7:0] b0;
        logic [7:0] b1;
        int         len;   // expected CE_N low cycles per byte
        int         tmo;
    } vec_t;

    vec_t vecs[9];

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    int ready_dly = 0;
    int lowk = 0;

    logic [7:0] byte_q[$];
    int len_q[$];
    int gap_q[$];
    int done_cnt, tmo_cnt, done_cyc;
    int orphan_tmo = 0, cewe_bad = 0, unstable = 0;
    int run, hi_run;
    bit seen;
    logic prev_ce = 1'b1;
    logic [7:0] cur;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        byte_q.delete();
        len_q.delete();
        gap_q.delete();
        done_cnt = 0;
        tmo_cnt  = 0;
        done_cyc = -1;
        seen     = 1'b0;
    endtask

    always @(posedge clock) cyc++;

    // Chip model: READY rises once the strobe has been low for ready_dly cycles.
    always @(posedge clock) begin
        #1;
        if (bus.CE_N === 1'b0) begin
            bus.READY = (lowk >= ready_dly);
            lowk++;
        end else begin
            bus.READY = 1'b0;
            lowk = 0;
        end
    end

    // Bus monitor: captures bytes, strobe widths and inter-byte high times.
    always @(negedge clock) begin
        if (bus.CE_N !== bus.WE_N) cewe_bad++;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.timeout_err === 1'b1) begin
            tmo_cnt++;
            if (bus.done !== 1'b1) orphan_tmo++;
        end
        if (bus.CE_N === 1'b0) begin
            if (prev_ce) begin
                byte_q.push_back(bus.D_OUT);
                cur = bus.D_OUT;
                run = 1;
                if (seen) gap_q.push_back(hi_run);
            end else begin
                run++;
                if (bus.D_OUT !== cur) unstable++;
            end
        end else begin
            if (!prev_ce) begin
                len_q.push_back(run);
                seen   = 1'b1;
                hi_run = 0;
            end
            hi_run++;
        end
        prev_ce = bus.CE_N;
    end

    task automatic set_req(input logic [1:0] ch, input logic attn, input logic [9:0] data);
        bus.req_channel = ch;
        bus.req_attn    = attn;
        bus.req_data    = data;
        bus.req_valid   = 1'b1;
    endtask

    // Holds req_valid until the handshake edge, then drops it.
    task automatic send(input logic [1:0] ch, input logic attn, input logic [9:0] data);
        bit acc = 1'b0;
        set_req(ch, attn, data);
        for (int i = 0; i < 600 && !acc; i++) begin
            if (bus.req_ready === 1'b1) acc = 1'b1;
            tick();
        end
        bus.req_valid = 1'b0;
        chk("accept", int'(acc), 1);
    endtask

    task automatic wait_done(input int n, input int limit);
        for (int i = 0; i < limit && done_cnt < n; i++) tick();
        chk("done_seen", int'(done_cnt >= n), 1);
    endtask

    initial begin
        vecs[0] = '{2'd0, 1'b0, 10'd10,    0,    2, 8'h51, 8'h00, 4,   0};
        vecs[1] = '{2'd1, 1'b1, 10'd5,     0,    1, 8'hAD, 8'h00, 4,   0};
        vecs[2] = '{2'd3, 1'b0, 10'd4,     0,    1, 8'h27, 8'h00, 4,   0};
        vecs[3] = '{2'd2, 1'b0, 10'h3FF,   40,   2, 8'hF3, 8'hFC, 41,  0};
        vecs[4] = '{2'd0, 1'b0, 10'd10,    1000, 1, 8'h51, 8'h00, 255, 1};
        vecs[5] = '{2'd2, 1'b1, 10'hF,     2,    1, 8'hFB, 8'h00, 4,   0};
        vecs[6] = '{2'd1, 1'b0, 10'h2A5,   5,    2, 8'hA5, 8'h54, 6,   0};
        vecs[7] = '{2'd3, 1'b0, 10'd3,     0,    1, 8'hC7, 8'h00, 4,   0};
        vecs[8] = '{2'd3, 1'b1, 10'h9,     0,    1, 8'h9F, 8'h00, 4,   0};

        reset = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_channel = 2'd0;
        bus.req_attn    = 1'b0;
        bus.req_data    = 10'd0;
        clear_mon();
        repeat (3) tick();
        chk("rst_ce_n",      int'(bus.CE_N), 1);
        chk("rst_we_n",      int'(bus.WE_N), 1);
        chk("rst_dout",      int'(bus.D_OUT), 'hFF);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_done",      int'(bus.done), 0);
        chk("rst_tmo",       int'(bus.timeout_err), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", int'(bus.req_ready), 1);
        tick();

        // First byte appears the cycle after accept, strobe one setup cycle later.
        clear_mon();
        ready_dly = 0;
        set_req(2'd0, 1'b0, 10'd10);
        tick();
        bus.req_valid = 1'b0;
        chk("lat_dout",   int'(bus.D_OUT), 'h51);
        chk("lat_setup",  int'(bus.CE_N), 1);
        chk("lat_busy",   int'(bus.req_ready), 0);
        tick();
        chk("lat_strobe", int'(bus.CE_N), 0);
        wait_done(1, 100);
        tick();
        chk("idle_hold_dout", int'(bus.D_OUT), 'h00);

        foreach (vecs[k]) begin
            clear_mon();
            ready_dly = vecs[k].dly;
            send(vecs[k].ch, vecs[k].attn, vecs[k].data);
            wait_done(1, 1000);
            repeat (4) tick();
            chk($sformatf("v%0d_nbytes", k), byte_q.size(), vecs[k].nb);
            if (byte_q.size() >= 1) chk($sformatf("v%0d_byte0", k), int'(byte_q[0]), int'(vecs[k].b0));
            if (vecs[k].nb == 2 && byte_q.size() >= 2) begin
                chk($sformatf("v%0d_byte1", k), int'(byte_q[1]), int'(vecs[k].b1));
                // High time between bytes spans the gap plus the next setup.
                if (gap_q.size() >= 1) chk($sformatf("v%0d_gap", k), gap_q[0], 3);
                else chk($sformatf("v%0d_gap_cnt", k), gap_q.size(), 1);
            end
            foreach (len_q[j]) chk($sformatf("v%0d_len%0d", k, j), len_q[j], vecs[k].len);
            chk($sformatf("v%0d_done_cnt", k), done_cnt, 1);
            chk($sformatf("v%0d_tmo_cnt", k), tmo_cnt, vecs[k].tmo);
        end

        // Back-to-back: second request held valid until IDLE is re-entered.
        begin
            int acc_cyc = -1;
            clear_mon();
            ready_dly = 0;
            send(2'd1, 1'b1, 10'd5);
            set_req(2'd3, 1'b0, 10'd4);
            for (int i = 0; i < 200 && acc_cyc < 0; i++) begin
                if (bus.req_ready === 1'b1) acc_cyc = cyc;
                tick();
            end
            bus.req_valid = 1'b0;
            chk("b2b_accept_after_done", acc_cyc, done_cyc + 1);
            wait_done(2, 200);
            repeat (4) tick();
            chk("b2b_nbytes", byte_q.size(), 2);
            if (byte_q.size() >= 2) begin
                chk("b2b_byte0", int'(byte_q[0]), 'hAD);
                chk("b2b_byte1", int'(byte_q[1]), 'h27);
            end
            chk("b2b_done_cnt", done_cnt, 2);
        end

        // Reset in the middle of a strobe aborts the request silently.
        begin
            bit low = 1'b0;
            clear_mon();
            ready_dly = 1000;
            send(2'd0, 1'b0, 10'd10);
            for (int i = 0; i < 20 && !low; i++) begin
                if (bus.CE_N === 1'b0) low = 1'b1;
                else tick();
            end
            chk("mid_strobe_reached", int'(low), 1);
            repeat (2) tick();
            reset = 1'b1;
            tick();
            chk("mid_rst_ce_n",  int'(bus.CE_N), 1);
            chk("mid_rst_we_n",  int'(bus.WE_N), 1);
            chk("mid_rst_dout",  int'(bus.D_OUT), 'hFF);
            chk("mid_rst_ready", int'(bus.req_ready), 0);
            tick();
            reset = 1'b0;
            ready_dly = 0;
            #1;
            chk("mid_rel_ready", int'(bus.req_ready), 1);
            repeat (20) tick();
            chk("mid_no_done",   done_cnt, 0);
            chk("mid_no_tmo",    tmo_cnt, 0);
            chk("mid_one_byte",  byte_q.size(), 1);
        end

        chk("ce_we_equal",     cewe_bad, 0);
        chk("dout_stable",     unstable, 0);
        chk("tmo_with_done",   orphan_tmo, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
